// File: rtl/fwrisc_mem_responder.sv
// Single-port word-wide memory serving the fwrisc fetch and data buses.
// Data has priority, but once a data grant has passed over a pending fetch,
// the fetch wins the next arbitration. Writes commit when the request is
// accepted. Completion is a one-cycle ready pulse after WAIT_STATES extra
// cycles.
module fwrisc_mem_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic [31:0] idata,
  output logic        iready,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        addr_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  // One past the last byte served; 33 bits so a window ending at 2^32 still works.
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + (33'd4 << ADDR_BITS);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   fair_q, fair_d;
  logic                   bus_d_q;
  logic [ADDR_BITS-1:0]   word_q;
  logic                   in_range_q;
  logic                   write_q;
  logic [31:0]            idata_q, drdata_q;
  logic                   iready_q, dready_q, err_q;
  logic [31:0]            mem_q [DEPTH];

  logic                   grant_d, grant_i, accept;
  logic [31:0]            req_addr;
  logic                   req_in_range;
  logic                   cur_bus_d, cur_in_range, cur_write;
  logic [ADDR_BITS-1:0]   cur_word;
  logic                   enter_resp;
  logic                   commit_we;

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  // Arbitration, fairness and next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and a latch is never inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    fair_d  = fair_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = dvalid && !(ivalid && fair_q);
        grant_i = !grant_d && ivalid;
        if (grant_d && ivalid) fair_d = 1'b1;
        if (grant_i)           fair_d = 1'b0;
        if (grant_d || grant_i) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction attributes: live request while idle, latched copy afterwards.
  always_comb begin
    accept       = grant_d || grant_i;
    req_addr     = grant_d ? daddr : iaddr;
    req_in_range = in_window(req_addr);
    if (state_q == ST_IDLE) begin
      cur_bus_d    = grant_d;
      cur_word     = req_addr[ADDR_BITS+1:2];
      cur_in_range = req_in_range;
      cur_write    = grant_d && dwrite;
    end else begin
      cur_bus_d    = bus_d_q;
      cur_word     = word_q;
      cur_in_range = in_range_q;
      cur_write    = write_q;
    end
    enter_resp = (state_d == ST_RESP);
    commit_we  = (state_q == ST_IDLE) && grant_d && dwrite && req_in_range;
  end

  // Control state, latched request and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      fair_q     <= 1'b0;
      bus_d_q    <= 1'b0;
      word_q     <= '0;
      in_range_q <= 1'b0;
      write_q    <= 1'b0;
      iready_q   <= 1'b0;
      dready_q   <= 1'b0;
      err_q      <= 1'b0;
      idata_q    <= 32'h0;
      drdata_q   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fair_q  <= fair_d;
      if (accept) begin
        bus_d_q    <= grant_d;
        word_q     <= req_addr[ADDR_BITS+1:2];
        in_range_q <= req_in_range;
        write_q    <= grant_d && dwrite;
      end
      iready_q <= enter_resp && !cur_bus_d;
      dready_q <= enter_resp && cur_bus_d;
      err_q    <= enter_resp && !cur_in_range;
      if (enter_resp && !cur_write) begin
        if (cur_bus_d) drdata_q <= cur_in_range ? mem_q[cur_word] : 32'h0;
        else           idata_q  <= cur_in_range ? mem_q[cur_word] : 32'h0;
      end
    end
  end

  // Byte-masked write port; commits on the acceptance edge.
  // NOTE: the storage array deliberately has no reset, so it maps onto plain RAM and keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (commit_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dwstb[b]) mem_q[req_addr[ADDR_BITS+1:2]][8*b +: 8] <= dwdata[8*b +: 8];
      end
    end
  end

  assign idata    = idata_q;
  assign drdata   = drdata_q;
  assign iready   = iready_q;
  assign dready   = dready_q;
  assign addr_err = err_q;

endmodule
